// File: rtl/tm1640_pkg.sv
// Shared TM1640 command bytes, link state encoding and display-control helper.
package tm1640_pkg;

  localparam logic [7:0] CMD_DATA = 8'h40;
  localparam logic [7:0] CMD_ADDR = 8'hC0;
  localparam logic [7:0] CMD_DISP = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT_LO,
    BIT_HI,
    STOP_A,
    STOP_B,
    STOP_C
  } state_t;

  function automatic logic [7:0] disp_ctl(input logic on, input logic [2:0] level);
    return CMD_DISP | {4'b0000, on, level};
  endfunction

endpackage

// File: rtl/tm1640_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV clocks while enabled, held at zero otherwise.
module tm1640_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tm1640_link.sv
// TM1640 two-wire link: each start sends data-command, address+segments and display-control frames.
// Optional macro TM1640_PENDING_EN merges starts seen while busy into one follow-up refresh.
module tm1640_link
  import tm1640_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_DIGITS = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*NUM_DIGITS-1:0] led_data,
  input  logic [2:0]              level,
  input  logic                    on,
  output logic                    tm_clk,
  output logic                    tm_din,
  output logic                    busy
);

  localparam int BW = $clog2(NUM_DIGITS + 1);

  state_t                  state;
  logic [2:0]              bit_cnt;
  logic [BW-1:0]           byte_idx;
  logic [1:0]              frame;
  logic [8*NUM_DIGITS-1:0] seg_sh;
  logic [2:0]              level_sh;
  logic                    on_sh;
  logic                    tick;
  logic                    go;

  logic [7:0]              cur_byte;
  logic [7:0]              nxt_byte;
  logic [2:0]              nxt_bit;
  logic [BW-1:0]           nxt_idx;
  logic [BW-1:0]           last_idx;
  logic                    last_bit;
  logic                    last_byte;

  tm1640_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // Byte at position idx within frame f; address 0 of frame 1 is the address command.
  function automatic logic [7:0] byte_value(input logic [1:0] f, input logic [BW-1:0] idx);
    logic [7:0] v;
    v = CMD_DATA;
    if (f == 2'd2) begin
      v = disp_ctl(on_sh, level_sh);
    end else if (f == 2'd1) begin
      v = CMD_ADDR;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (idx == BW'(d + 1)) v = seg_sh[8*d +: 8];
      end
    end
    return v;
  endfunction

  always_comb begin
    last_idx  = (frame == 2'd1) ? BW'(NUM_DIGITS) : '0;
    last_bit  = (bit_cnt == 3'd7);
    last_byte = (byte_idx == last_idx);
    nxt_bit   = bit_cnt + 3'd1;
    nxt_idx   = last_bit ? byte_idx + 1'b1 : byte_idx;
    cur_byte  = byte_value(frame, byte_idx);
    nxt_byte  = byte_value(frame, nxt_idx);
  end

`ifdef TM1640_PENDING_EN
  logic pending;

  assign go = start || pending;
`else
  assign go = start;
`endif

  // Entering START drives the start condition at once; every later line change waits for a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tm_clk   <= 1'b1;
      tm_din   <= 1'b1;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      frame    <= '0;
      seg_sh   <= '0;
      level_sh <= '0;
      on_sh    <= 1'b0;
`ifdef TM1640_PENDING_EN
      pending  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (go) begin
        seg_sh   <= led_data;
        level_sh <= level;
        on_sh    <= on;
        state    <= START;
        tm_clk   <= 1'b1;
        tm_din   <= 1'b0;
        busy     <= 1'b1;
        frame    <= '0;
        byte_idx <= '0;
        bit_cnt  <= '0;
`ifdef TM1640_PENDING_EN
        pending  <= 1'b0;
`endif
      end
    end else begin
`ifdef TM1640_PENDING_EN
      if (start) pending <= 1'b1;
`endif
      if (tick) begin
        case (state)
          START: begin
            state  <= BIT_LO;
            tm_clk <= 1'b0;
            tm_din <= cur_byte[bit_cnt];
          end
          BIT_LO: begin
            state  <= BIT_HI;
            tm_clk <= 1'b1;
          end
          BIT_HI: begin
            tm_clk <= 1'b0;
            if (last_bit && last_byte) begin
              state  <= STOP_A;
              tm_din <= 1'b0;
            end else begin
              state    <= BIT_LO;
              bit_cnt  <= nxt_bit;
              byte_idx <= nxt_idx;
              tm_din   <= nxt_byte[nxt_bit];
            end
          end
          STOP_A: begin
            state  <= STOP_B;
            tm_clk <= 1'b1;
          end
          STOP_B: begin
            state  <= STOP_C;
            tm_din <= 1'b1;
          end
          STOP_C: begin
            if (frame == 2'd2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= START;
              frame    <= frame + 2'd1;
              byte_idx <= '0;
              bit_cnt  <= '0;
              tm_din   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm1640_link.sv
// Directed and randomized checks of tm1640_link against a bus-decoding reference monitor.
module tb_tm1640_link;

  localparam int CLK_DIV   = 2;
  localparam int ND        = 9;
  localparam int HALVES    = 3 * 4 + 16 * (ND + 3);
  localparam int BUSY_CLKS = HALVES * CLK_DIV;

  logic            clk;
  logic            rst;
  logic            start;
  logic [8*ND-1:0] led_data;
  logic [2:0]      level;
  logic            on;
  logic            tm_clk;
  logic            tm_din;
  logic            busy;

  int total;
  int bad;
  int sptr;
  int bptr;

  bit         bits[$];
  logic [7:0] got_bytes[$];
  int         got_sizes[$];
  int         proto_err;
  int         rise_count;
  logic       pc = 1'b1;
  logic       pd = 1'b1;
  bit         in_frame;

  tm1640_link #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .led_data (led_data),
    .level    (level),
    .on       (on),
    .tm_clk   (tm_clk),
    .tm_din   (tm_din),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus decoder: start/stop conditions frame the bits sampled on each rising tm_clk.
  always @(negedge clk) begin
    int n;
    logic [7:0] v;
    if (!rst) begin
      in_frame = 1'b0;
      bits.delete();
    end else if (pc && tm_clk && pd && !tm_din) begin
      if (in_frame) proto_err++;
      in_frame = 1'b1;
      bits.delete();
    end else if (pc && tm_clk && !pd && tm_din) begin
      if (!in_frame || bits.size() == 0 || bits[bits.size()-1] != 1'b0 || (bits.size() - 1) % 8 != 0) begin
        proto_err++;
      end else begin
        n = (bits.size() - 1) / 8;
        for (int b = 0; b < n; b++) begin
          for (int k = 0; k < 8; k++) v[k] = bits[8*b + k];
          got_bytes.push_back(v);
        end
        got_sizes.push_back(n);
      end
      in_frame = 1'b0;
    end else if (!pc && tm_clk) begin
      rise_count++;
      if (in_frame) bits.push_back(tm_din);
      else proto_err++;
    end
    pc = tm_clk;
    pd = tm_din;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [8*ND-1:0] d, input logic [2:0] lv, input logic o);
    @(negedge clk);
    led_data = d;
    level    = lv;
    on       = o;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", busy, 1'b1);
  endtask

  // Counts clocks with busy high; action 1 scrambles inputs, action 2 pulses start, at clock mid.
  task automatic waitBusyLow(output int len, input int mid, input int action);
    len = 0;
    while (busy && len < BUSY_CLKS + 50) begin
      len++;
      if (len == mid && action == 1) begin
        led_data = ~led_data;
        level    = level + 3'd3;
        on       = ~on;
      end
      if (len == mid && action == 2) start = 1'b1;
      if (len == mid + 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic expectRefresh(input logic [8*ND-1:0] d, input logic [2:0] lv, input logic o);
    logic [7:0] exp_q[$];
    int sizes[3];
    int e;
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < ND; i++) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(8'h80 + (o ? 8'd8 : 8'd0) + {5'd0, lv});
    sizes[0] = 1;
    sizes[1] = ND + 1;
    sizes[2] = 1;
    e = 0;
    checkOutput("frame count", got_sizes.size() - sptr, 3);
    for (int f = 0; f < 3; f++) begin
      if (sptr < got_sizes.size()) begin
        checkOutput($sformatf("frame%0d size", f), got_sizes[sptr], sizes[f]);
        for (int k = 0; k < sizes[f] && k < got_sizes[sptr]; k++) begin
          checkOutput($sformatf("frame%0d byte%0d", f, k), got_bytes[bptr + k], exp_q[e + k]);
        end
        bptr += got_sizes[sptr];
        sptr++;
      end
      e += sizes[f];
    end
  endtask

  function automatic logic [8*ND-1:0] randData();
    logic [8*ND-1:0] d;
    for (int i = 0; i < ND; i++) d[8*i +: 8] = 8'($urandom);
    return d;
  endfunction

  initial begin
    logic [7:0]      digits[ND];
    logic [8*ND-1:0] d;
    logic [2:0]      lv;
    logic            o;
    int              len;
    int              r0;

    total = 0;
    bad   = 0;
    sptr  = 0;
    bptr  = 0;
    rst      = 1'b0;
    start    = 1'b0;
    led_data = '0;
    level    = '0;
    on       = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset tm_clk", tm_clk, 1'b1);
    checkOutput("reset tm_din", tm_din, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    r0 = rise_count;
    repeat (1000) @(negedge clk);
    checkOutput("idle edges", rise_count - r0, 0);
    checkOutput("idle busy", busy, 1'b0);

    digits = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    for (int i = 0; i < ND; i++) d[8*i +: 8] = digits[i];
    applyStimulus(d, 3'd4, 1'b1);
    waitBusyLow(len, 0, 0);
    checkOutput("basic busy length", len, BUSY_CLKS);
    repeat (3) @(negedge clk);
    expectRefresh(d, 3'd4, 1'b1);

    d = randData();
    applyStimulus(d, 3'd7, 1'b0);
    waitBusyLow(len, 60, 1);
    checkOutput("off busy length", len, BUSY_CLKS);
    repeat (3) @(negedge clk);
    expectRefresh(d, 3'd7, 1'b0);

    for (int r = 0; r < 4; r++) begin
      d  = randData();
      lv = 3'($urandom);
      o  = 1'($urandom);
      applyStimulus(d, lv, o);
      waitBusyLow(len, 0, 0);
      checkOutput($sformatf("rand%0d busy length", r), len, BUSY_CLKS);
      repeat (2 + $urandom_range(0, 5)) @(negedge clk);
      expectRefresh(d, lv, o);
    end

    d = randData();
    applyStimulus(d, 3'd2, 1'b1);
    waitBusyLow(len, 100, 2);
    checkOutput("busy length with extra start", len, BUSY_CLKS);
`ifdef TM1640_PENDING_EN
    checkOutput("pending gap busy low", busy, 1'b0);
    @(negedge clk);
    checkOutput("pending refresh busy", busy, 1'b1);
    waitBusyLow(len, 0, 0);
    checkOutput("pending busy length", len, BUSY_CLKS);
    repeat (3) @(negedge clk);
    expectRefresh(d, 3'd2, 1'b1);
    expectRefresh(d, 3'd2, 1'b1);
`else
    repeat (20) @(negedge clk);
    checkOutput("dropped start busy", busy, 1'b0);
    expectRefresh(d, 3'd2, 1'b1);
    checkOutput("no extra frames", got_sizes.size() - sptr, 0);
`endif

    d = randData();
    applyStimulus(d, 3'd5, 1'b1);
    repeat (149) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset tm_clk", tm_clk, 1'b1);
    checkOutput("async reset tm_din", tm_din, 1'b1);
    checkOutput("async reset busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sptr = got_sizes.size();
    bptr = got_bytes.size();
    @(negedge clk);
    checkOutput("post reset busy", busy, 1'b0);
    d  = randData();
    lv = 3'($urandom);
    applyStimulus(d, lv, 1'b1);
    waitBusyLow(len, 0, 0);
    checkOutput("post reset busy length", len, BUSY_CLKS);
    repeat (3) @(negedge clk);
    expectRefresh(d, lv, 1'b1);

    checkOutput("protocol violations", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tm1640_link.md
Name: tm1640_link

Overview:
- Serial link stage that consumes the packed 9-digit segment image produced by the counter/demo logic.
- Drives the TM1640 two-wire bus (tm_clk/tm_din) on the 7seg9 PMOD.
- Each start request sends one complete refresh as three bus frames: data command, address plus segment bytes, then display control.
- busy is exposed so the producer can pace its updates.

Parameters:
- CLK_DIV, 4, system clocks per bus half-period (>=1); bus bit rate = clk/(2*CLK_DIV).
- NUM_DIGITS, 9, number of segment bytes sent per refresh.

Ports:
- clk  input  1  system clock, all logic posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle refresh request; sampled only when idle.
- led_data  input  8*NUM_DIGITS  packed segments; bits [7:0] = digit 1 (address 0), [15:8] = digit 2, etc.
- level  input  3  brightness 0..7.
- on  input  1  display enable.
- tm_clk  output  1  bus clock, registered.
- tm_din  output  1  bus data, registered.
- busy  output  1  high from the cycle after start is accepted until the final stop completes.

Behaviour:
- Reset (async, rst=0): state IDLE; tm_clk=1, tm_din=1, busy=0, divider=0, pending cleared. These take effect immediately, including when reset is asserted mid-frame.
- Half-period tick: fires every CLK_DIV clocks while not IDLE. All bus line changes happen only on a tick.
- Start acceptance: start=1 in IDLE latches led_data, level and on into shadow registers. busy=1 on the next clock.
  - Inputs may change freely afterwards.
  - start while busy is ignored, unless the Optional Feature is compiled in.
- Frame 0 bytes: 0x40 (write data, auto-increment).
- Frame 1 bytes: 0xC0, then the NUM_DIGITS segment bytes in address order.
- Frame 2 bytes: 0x80 | (on<<3) | level. Examples: on=1, level=4 gives 0x8C; on=0, level=7 gives 0x87.
- States: IDLE -> START -> BIT_LO -> BIT_HI -> (repeat per bit/byte) -> STOP_A -> STOP_B -> STOP_C -> START of next frame, or IDLE after frame 2.
- START (1 half): tm_clk=1, tm_din=0.
- BIT_LO (1 half): tm_clk=0, tm_din=current bit. Bits go LSB first.
- BIT_HI (1 half): tm_clk=1, tm_din held. The TM1640 samples on this rising edge.
- STOP_A: clk=0, din=0. STOP_B: clk=1, din=0. STOP_C: clk=1, din=1.
- Frame length in half-periods: 4 + 16*bytes.
  - With NUM_DIGITS=9: 20 + 164 + 20 = 204 halves.
  - busy lasts 204*CLK_DIV clocks; it falls in the clock where STOP_C of frame 2 ends.
- Counters: bit counter 3-bit, wraps 7->0 and advances the byte index. Byte index width is clog2(NUM_DIGITS+1). Frame index 0..2.
- tm_din never changes while tm_clk=1, except in the START and STOP_C halves (the protocol start/stop conditions).
- start asserted in the same cycle busy falls: not accepted, because the block is not yet IDLE. It is accepted from the following cycle.

Optional Feature:
- Macro TM1640_PENDING_EN.
- Defined: a start seen while busy sets a pending flag; further requests while pending stay merged into the one flag.
  - On completion the block returns to IDLE for exactly one clock, with busy low for that cycle.
  - In that IDLE clock it re-latches the current inputs and begins the new refresh (busy high again on the next clock).
  - Reset clears pending.
- Undefined: starts during busy are dropped; no pending register is synthesized.

Decomposition:
- Shared package tm1640_pkg holds:
  - command constants CMD_DATA=8'h40, CMD_ADDR=8'hC0, CMD_DISP=8'h80;
  - state enum (IDLE, START, BIT_LO, BIT_HI, STOP_A, STOP_B, STOP_C);
  - function disp_ctl(on, level).
- One natural sub-module: tm1640_tick, the CLK_DIV half-period divider. It has enable and async active-low reset, and emits a single-cycle tick.

Test Plan:
- Reset then idle: hold rst=0 for 3 clocks, release -> tm_clk=1, tm_din=1, busy=0; no edges on tm_clk for 1000 clocks.
- Basic refresh: CLK_DIV=2, led_data bytes 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F, level=4, on=1, pulse start.
  - Bus monitor decodes frames [0x40], [0xC0,0x3F,...,0x7F], [0x8C].
  - busy high for exactly 408 clocks.
- Display off: on=0, level=7 -> third frame byte 0x87. Change led_data mid-transfer -> decoded bytes still equal the latched values.
- Start during busy (macro undefined): second start pulse at clock 100 -> exactly one refresh, busy falls at 408.
  - With TM1640_PENDING_EN: a second refresh follows, busy low for exactly one clock.
- Reset mid-frame: assert rst at clock 150 -> tm_clk=1, tm_din=1, busy=0 asynchronously. After release, start gives a full, correctly decoded refresh.
- Protocol check across all runs: assertion that tm_din toggles while tm_clk=1 only at start/stop conditions, and each frame has exactly 8*bytes rising edges.
